_romarb: RTL and testbench
==========================

# _romarb

Two-port round-robin arbiter and access sequencer for one shared `_genrom` instance. Two requesters, typically a microprogram fetch path and a mapping/table lookup, each present an address with a request. The block grants one at a time. It drives the ROM address and the active-low chip select for a configurable number of wait states, registers the ROM output, and returns it with a one-cycle acknowledge. It sits between the requesters and the ROM; the ROM's second chip select is tied low at the instance.

## Interface
- `WIDTH`, 4: ROM data width in bits.
- `HEIGHT`, 8: ROM address width in bits.
- `WAIT`, 1: extra ROM access cycles, legal range 0..15. The chip select stays low for `WAIT`+1 cycles per access.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` in 1: request from port 0, level-sensitive.
- `a0` in HEIGHT: port 0 address, sampled at grant.
- `req1` in 1: request from port 1.
- `a1` in HEIGHT: port 1 address, sampled at grant.
- `ack0` out 1: one-cycle pulse; `q` is valid for port 0.
- `ack1` out 1: one-cycle pulse; `q` is valid for port 1.
- `q` out WIDTH: registered read data, shared by both ports.
- `busy` out 1: high in ACCESS and DONE.
- `rom_a` out HEIGHT: address to the ROM `a` input.
- `rom_cs_` out 1: active-low chip select to ROM `cs1_`.
- `rom_q` in WIDTH: ROM data output.

## Operation
States: IDLE, ACCESS, DONE.

Registers:
- `last`: the port served most recently.
- `cnt`: 4-bit wait counter.
- `rom_a`: latched address.
- `q`: data register.

IDLE:
- `rom_cs_`=1, `ack0`=`ack1`=0.
- If any request is present at an edge: choose the port, latch its address into `rom_a`, set `last` to that port, load `cnt`=`WAIT`, and go to ACCESS.
- Port selection: only `req0` selects 0; only `req1` selects 1. If both are high, select the port not equal to `last`.

ACCESS:
- `rom_cs_`=0 and `rom_a` is held.
- At each edge, if `cnt`==0: capture `rom_q` into `q`, assert the granted port's ack, and go to DONE. Otherwise decrement `cnt`.

DONE:
- `rom_cs_`=1 and the granted ack=1. Exactly one ack is high.
- Next edge: ack drops and the state goes to IDLE unconditionally.

Port behaviour:
- A requester holding `req` high past its ack is treated as a new request in the next IDLE cycle, subject to arbitration.
- Dropping `req` during ACCESS does not abort: the access completes and the ack still pulses.
- Changing `a0`/`a1` after grant has no effect on the current access.

`q` keeps its value until the next capture. It is not cleared when ack drops.

Reset (`rst`=1 at an edge, in any state including mid-ACCESS):
- State=IDLE, `rom_cs_`=1, `rom_a`=0, `q`=0, `ack0`=`ack1`=0, `busy`=0.
- `last`=1, so port 0 wins the first tie. `cnt`=0.
- An aborted access produces no ack.

## Timing
- Request high before edge k while IDLE: grant at edge k, and `rom_cs_` falls after edge k.
- Data is captured at edge k+`WAIT`+1; the ack is high for the cycle after it.
- The state returns to IDLE at edge k+`WAIT`+2.
- Request-to-ack latency is `WAIT`+2 edges.
- Back-to-back service takes `WAIT`+3 cycles per access, including one IDLE cycle.
- `rom_q` must settle within `WAIT`+1 cycles of `rom_a`/`rom_cs_` changing. There is no combinational path from `rom_q` to any output.
- `ack0`, `ack1`, `q`, `busy`, `rom_a` and `rom_cs_` are all registered.

## Test plan
- **Reset:** hold `rst` 2 cycles with the ROM preloaded -> `rom_cs_`=1, `rom_a`=0, `q`=0, acks 0, `busy`=0.
- **Single read, WAIT=1:** `req0`=1, `a0`=8'h12, ROM[12h]=4'hA.
  - `rom_cs_` low for exactly 2 cycles.
  - `ack0` high for 1 cycle, 3 edges after the request edge, with `q`=4'hA.
  - `ack1` stays 0.
- **Simultaneous requests held high, WAIT=0:** `req0`=`req1`=1, `a0`=1, `a1`=2, ROM[1]=3, ROM[2]=5.
  - Grants alternate 0,1,0,1. `q` reads 3,5,3,5 on `ack0`,`ack1`,`ack0`,`ack1`.
  - Each ack is 3 cycles apart.
- **Address change after grant:** `req1` granted with `a1`=4; change `a1`=9 during ACCESS -> `rom_a` stays 4, and `q`=ROM[4] at `ack1`.
- **Reset mid-access, WAIT=3:** pulse `rst` in the 2nd ACCESS cycle -> next cycle IDLE, `rom_cs_`=1, no ack. A subsequent `req1`-only request is served normally.
- **Withdrawn request:** drop `req0` one cycle after grant -> `ack0` still pulses at the normal time, then IDLE with no re-grant.

Source files
------------

// File: rtl/_romarb_if.sv
// rtl/_romarb_if.sv - requester, ROM and arbiter signal bundle for _romarb
interface _romarb_if #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 8
);
    logic              req0;
    logic [HEIGHT-1:0] a0;
    logic              req1;
    logic [HEIGHT-1:0] a1;
    logic              ack0;
    logic              ack1;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic [HEIGHT-1:0] rom_a;
    logic              rom_cs_;
    logic [WIDTH-1:0]  rom_q;

    // master is the environment: both requesters plus the ROM data return
    modport master (
        output req0, a0, req1, a1, rom_q,
        input  ack0, ack1, q, busy, rom_a, rom_cs_
    );

    modport slave (
        input  req0, a0, req1, a1, rom_q,
        output ack0, ack1, q, busy, rom_a, rom_cs_
    );
endinterface

// File: rtl/_romarb.sv
// rtl/_romarb.sv - two-port round-robin arbiter and wait-state sequencer for one shared ROM
module _romarb #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 8,
    parameter int WAIT   = 1
) (
    input  logic      clk,
    input  logic      rst,
    _romarb_if.slave  bus
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic              last;
    logic [3:0]        cnt;
    logic [HEIGHT-1:0] rom_a_r;
    logic [WIDTH-1:0]  q_r;
    logic              rom_cs_r;
    logic              ack0_r;
    logic              ack1_r;
    logic              busy_r;

    // On a tie the port that was not served last wins
    logic sel;
    assign sel = (bus.req0 && bus.req1) ? ~last : bus.req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            cnt      <= 4'd0;
            rom_a_r  <= '0;
            q_r      <= '0;
            rom_cs_r <= 1'b1;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        rom_a_r  <= sel ? bus.a1 : bus.a0;
                        last     <= sel;
                        cnt      <= WAIT_CNT;
                        rom_cs_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        q_r      <= bus.rom_q;
                        ack0_r   <= ~last;
                        ack1_r   <= last;
                        rom_cs_r <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rom_cs_r <= 1'b1;
                    ack0_r   <= 1'b0;
                    ack1_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_a   = rom_a_r;
    assign bus.rom_cs_ = rom_cs_r;
    assign bus.q       = q_r;
    assign bus.ack0    = ack0_r;
    assign bus.ack1    = ack1_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb__romarb.sv
// tb/tb__romarb.sv - vector table and randomized model checks for _romarb at WAIT 0, 1 and 3
module tb__romarb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] a0 = 8'h00;
    logic [7:0] a1 = 8'h00;
    logic [3:0] rom [256];
    logic [15:0] obs [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int W = (i == 0) ? 0 : (i == 1) ? 1 : 3;
        _romarb_if #(.WIDTH(4), .HEIGHT(8)) bus ();
        _romarb #(.WIDTH(4), .HEIGHT(8), .WAIT(W)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.req0  = req0;
        assign bus.a0    = a0;
        assign bus.req1  = req1;
        assign bus.a1    = a1;
        assign bus.rom_q = bus.rom_cs_ ? 4'h0 : rom[bus.rom_a];
        assign obs[i]    = {bus.rom_cs_, bus.ack0, bus.ack1, bus.busy, bus.rom_a, bus.q};
    end

    // One row = inputs held across one rising edge and the outputs expected after it
    typedef struct {
        int         inst;
        bit         rs;
        bit         r0;
        logic [7:0] av0;
        bit         r1;
        logic [7:0] av1;
        logic [15:0] exp;
    } vec_t;

    function automatic vec_t mk(int inst, bit rs, bit r0, logic [7:0] av0, bit r1, logic [7:0] av1,
                                bit cs, bit k0, bit k1, bit bz, logic [7:0] ra, logic [3:0] qq);
        vec_t v;
        v.inst = inst; v.rs = rs; v.r0 = r0; v.av0 = av0; v.r1 = r1; v.av1 = av1;
        v.exp  = {cs, k0, k1, bz, ra, qq};
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got cs_=%b ack0=%b ack1=%b busy=%b rom_a=%h q=%h, want cs_=%b ack0=%b ack1=%b busy=%b rom_a=%h q=%h",
                     name, act[15], act[14], act[13], act[12], act[11:4], act[3:0],
                     exp[15], exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
        end
    endtask

    // Reference model: each instance remembers its latest grant edge and derives
    // its phase purely from the distance to that edge
    int         wv [3] = '{0, 1, 3};
    bit         m_act  [3];
    int         m_g    [3];
    bit         m_p    [3];
    logic [7:0] m_addr [3];
    bit         m_last [3];
    logic [3:0] m_q    [3];

    task automatic model_edge(int n);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_act[k] = 0; m_last[k] = 1; m_q[k] = 4'h0; m_addr[k] = 8'h00;
            end else begin
                bit idle;
                idle = !m_act[k] || (n - m_g[k] >= wv[k] + 3);
                if (idle && (req0 || req1)) begin
                    bit p;
                    p = (req0 && req1) ? !m_last[k] : req1;
                    m_act[k] = 1; m_g[k] = n; m_p[k] = p;
                    m_addr[k] = p ? a1 : a0; m_last[k] = p;
                end
                if (m_act[k] && (n - m_g[k] == wv[k] + 1)) m_q[k] = rom[m_addr[k]];
            end
        end
    endtask

    function automatic logic [15:0] model_out(int k, int n);
        int d;
        d = n - m_g[k];
        if (m_act[k] && d <= wv[k])
            return {1'b0, 1'b0, 1'b0, 1'b1, m_addr[k], m_q[k]};
        else if (m_act[k] && d == wv[k] + 1)
            return {1'b1, !m_p[k], m_p[k], 1'b1, m_addr[k], m_q[k]};
        else
            return {1'b1, 1'b0, 1'b0, 1'b0, m_addr[k], m_q[k]};
    endfunction

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
        rom[8'h12] = 4'hA; rom[1] = 4'h3; rom[2] = 4'h5; rom[4] = 4'h7; rom[9] = 4'hC;

        // reset, then single read at WAIT=1
        vecs.push_back(mk(1,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(1,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(1,0, 1,8'h12,0,8'h00, 0,0,0,1,8'h12,4'h0));
        vecs.push_back(mk(1,0, 0,8'h12,0,8'h00, 0,0,0,1,8'h12,4'h0));
        vecs.push_back(mk(1,0, 0,8'h00,0,8'h00, 1,1,0,1,8'h12,4'hA));
        vecs.push_back(mk(1,0, 0,8'h00,0,8'h00, 1,0,0,0,8'h12,4'hA));
        // both held high at WAIT=0: grants alternate starting with port 0
        vecs.push_back(mk(0,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(0,0, 1,8'h01,1,8'h02, 0,0,0,1,8'h01,(r == 0) ? 4'h0 : 4'h5));
            vecs.push_back(mk(0,0, 1,8'h01,1,8'h02, 1,1,0,1,8'h01,4'h3));
            vecs.push_back(mk(0,0, 1,8'h01,1,8'h02, 1,0,0,0,8'h01,4'h3));
            vecs.push_back(mk(0,0, 1,8'h01,1,8'h02, 0,0,0,1,8'h02,4'h3));
            vecs.push_back(mk(0,0, 1,8'h01,1,8'h02, 1,0,1,1,8'h02,4'h5));
            vecs.push_back(mk(0,0, (r == 0),8'h01,(r == 0),8'h02, 1,0,0,0,8'h02,4'h5));
        end
        vecs.push_back(mk(0,0, 0,8'h01,0,8'h02, 1,0,0,0,8'h02,4'h5));
        // address change after grant
        vecs.push_back(mk(1,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(1,0, 0,8'h00,1,8'h04, 0,0,0,1,8'h04,4'h0));
        vecs.push_back(mk(1,0, 0,8'h00,0,8'h09, 0,0,0,1,8'h04,4'h0));
        vecs.push_back(mk(1,0, 0,8'h00,0,8'h09, 1,0,1,1,8'h04,4'h7));
        vecs.push_back(mk(1,0, 0,8'h00,0,8'h09, 1,0,0,0,8'h04,4'h7));
        // reset in the second access cycle at WAIT=3, then a port 1 read
        vecs.push_back(mk(2,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(2,0, 1,8'h12,0,8'h00, 0,0,0,1,8'h12,4'h0));
        vecs.push_back(mk(2,0, 0,8'h12,0,8'h00, 0,0,0,1,8'h12,4'h0));
        vecs.push_back(mk(2,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(2,0, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(2,0, 0,8'h00,1,8'h02, 0,0,0,1,8'h02,4'h0));
        for (int r = 0; r < 3; r++)
            vecs.push_back(mk(2,0, 0,8'h00,0,8'h02, 0,0,0,1,8'h02,4'h0));
        vecs.push_back(mk(2,0, 0,8'h00,0,8'h02, 1,0,1,1,8'h02,4'h5));
        vecs.push_back(mk(2,0, 0,8'h00,0,8'h02, 1,0,0,0,8'h02,4'h5));
        vecs.push_back(mk(2,0, 0,8'h00,0,8'h02, 1,0,0,0,8'h02,4'h5));
        // withdrawn request still completes, no re-grant
        vecs.push_back(mk(1,1, 0,8'h00,0,8'h00, 1,0,0,0,8'h00,4'h0));
        vecs.push_back(mk(1,0, 1,8'h01,0,8'h00, 0,0,0,1,8'h01,4'h0));
        vecs.push_back(mk(1,0, 0,8'h01,0,8'h00, 0,0,0,1,8'h01,4'h0));
        vecs.push_back(mk(1,0, 0,8'h01,0,8'h00, 1,1,0,1,8'h01,4'h3));
        vecs.push_back(mk(1,0, 0,8'h01,0,8'h00, 1,0,0,0,8'h01,4'h3));
        vecs.push_back(mk(1,0, 0,8'h01,0,8'h00, 1,0,0,0,8'h01,4'h3));

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rs; req0 = vecs[i].r0; a0 = vecs[i].av0;
            req1 = vecs[i].r1; a1 = vecs[i].av1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_w%0d", i, wv[vecs[i].inst]), obs[vecs[i].inst], vecs[i].exp);
        end

        // randomized traffic, all three wait settings against the model
        for (int n = 0; n < 2000; n++) begin
            rst  = (n < 2) || ($urandom_range(0, 99) == 0);
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) == 0);
            a0   = 8'($urandom);
            a1   = 8'($urandom);
            @(posedge clk); #1;
            model_edge(n);
            for (int k = 0; k < 3; k++)
                check($sformatf("rand%0d_w%0d", n, wv[k]), obs[k], model_out(k, n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
